// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter: shares one 64-bit AXI-Stream output between
// NUM_PORTS sources, holding each grant from first beat through tlast.
module axis_pkt_arbiter #(
    parameter  int NUM_PORTS  = 4,
    parameter  int GAP_CYCLES = 0,
    localparam int IDW        = $clog2(NUM_PORTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [64*NUM_PORTS-1:0]   in_tdata,
    input  logic [8*NUM_PORTS-1:0]    in_tkeep,
    input  logic [NUM_PORTS-1:0]      in_tvalid,
    input  logic [NUM_PORTS-1:0]      in_tlast,
    output logic [NUM_PORTS-1:0]      in_tready,
    output logic [63:0]               out_tdata,
    output logic [7:0]                out_tkeep,
    output logic                      out_tvalid,
    output logic                      out_tlast,
    input  logic                      out_tready,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy,
    output logic [31:0]               pkt_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [7:0]     GAP_LOAD  = 8'(GAP_CYCLES);
    localparam logic [IDW-1:0] LAST_PORT = IDW'(NUM_PORTS - 1);

    logic [1:0]     r_state;
    logic [IDW-1:0] r_grant_id;
    logic [IDW-1:0] r_last_grant;
    logic [31:0]    r_pkt_count;
    logic [7:0]     r_gap_cnt;

    logic                 w_pass;
    logic                 w_any_req;
    logic [IDW-1:0]       w_winner;
    logic [NUM_PORTS-1:0] w_gnt_hot;
    logic [63:0]          w_sel_tdata;
    logic [7:0]           w_sel_tkeep;
    logic                 w_sel_tvalid;
    logic                 w_sel_tlast;
    logic                 w_pkt_end;

    assign w_pass    = (r_state == ST_PASS);
    assign w_any_req = |in_tvalid;

    // Scan from the highest offset down so the nearest requester after
    // last_grant is the one left in w_winner.
    always_comb begin
        int idx;
        w_winner = r_last_grant;
        idx      = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = int'(r_last_grant) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (in_tvalid[idx]) begin
                w_winner = IDW'(idx);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_gnt_hot[gi] = (r_grant_id == IDW'(gi));
            assign in_tready[gi] = w_pass & w_gnt_hot[gi] & out_tready;
        end
    endgenerate

    assign w_sel_tdata  = in_tdata[64*int'(r_grant_id) +: 64];
    assign w_sel_tkeep  = in_tkeep[8*int'(r_grant_id) +: 8];
    assign w_sel_tvalid = in_tvalid[r_grant_id];
    assign w_sel_tlast  = in_tlast[r_grant_id];

    // Zero-latency pass-through; everything is forced to zero outside PASS.
    assign out_tdata  = w_pass ? w_sel_tdata : 64'd0;
    assign out_tkeep  = w_pass ? w_sel_tkeep : 8'd0;
    assign out_tvalid = w_pass & w_sel_tvalid;
    assign out_tlast  = w_pass & w_sel_tlast;

    assign w_pkt_end = out_tvalid & out_tready & out_tlast;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= LAST_PORT;
            r_pkt_count  <= 32'd0;
            r_gap_cnt    <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        r_state      <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (w_pkt_end) begin
                        r_pkt_count <= r_pkt_count + 32'd1;
                        if (GAP_CYCLES > 0) begin
                            r_state   <= ST_GAP;
                            r_gap_cnt <= GAP_LOAD;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_GAP: begin
                    // Leave on the cycle the counter shows 1 so GAP lasts exactly GAP_CYCLES.
                    if (r_gap_cnt <= 8'd1) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant_id  = r_grant_id;
    assign busy      = w_pass;
    assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: a directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a packet-level model.
module tb_axis_pkt_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [64*N-1:0]    in_tdata;
    logic [8*N-1:0]     in_tkeep;
    logic [N-1:0]       in_tvalid;
    logic [N-1:0]       in_tlast;
    logic               out_tready;

    logic [N-1:0] tr0, tr3;
    logic [63:0]  od0, od3;
    logic [7:0]   ok0, ok3;
    logic         ov0, ov3, ol0, ol3, busy0, busy3;
    logic [1:0]   gid0, gid3;
    logic [31:0]  cnt0, cnt3;

    axis_pkt_arbiter #(.NUM_PORTS(N), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid),
        .in_tlast(in_tlast), .in_tready(tr0),
        .out_tdata(od0), .out_tkeep(ok0), .out_tvalid(ov0), .out_tlast(ol0),
        .out_tready(out_tready), .grant_id(gid0), .busy(busy0), .pkt_count(cnt0)
    );

    axis_pkt_arbiter #(.NUM_PORTS(N), .GAP_CYCLES(3)) dut_g (
        .clk(clk), .rst_n(rst_n),
        .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid),
        .in_tlast(in_tlast), .in_tready(tr3),
        .out_tdata(od3), .out_tkeep(ok3), .out_tvalid(ov3), .out_tlast(ol3),
        .out_tready(out_tready), .grant_id(gid3), .busy(busy3), .pkt_count(cnt3)
    );

    // Which instance the model-driven runs observe: 0 -> no gap, 1 -> GAP_CYCLES=3.
    bit sel_g;
    logic [N-1:0] s_tr;
    logic [63:0]  s_od;
    logic [7:0]   s_ok;
    logic         s_ov, s_ol, s_busy;
    logic [1:0]   s_gid;
    logic [31:0]  s_cnt;
    always_comb begin
        s_tr   = sel_g ? tr3   : tr0;
        s_od   = sel_g ? od3   : od0;
        s_ok   = sel_g ? ok3   : ok0;
        s_ov   = sel_g ? ov3   : ov0;
        s_ol   = sel_g ? ol3   : ol0;
        s_busy = sel_g ? busy3 : busy0;
        s_gid  = sel_g ? gid3  : gid0;
        s_cnt  = sel_g ? cnt3  : cnt0;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          port;
        bit          vld;
        logic [63:0] data;
        logic [7:0]  keep;
        bit          last;
        bit          rdy;
        bit          e_ov;
        logic [63:0] e_od;
        logic [7:0]  e_ok;
        bit          e_ol;
        logic [3:0]  e_tr;
        logic [1:0]  e_gid;
        bit          e_busy;
        int          e_cnt;
    } vec_t;

    function automatic vec_t mv(int port, bit vld, logic [63:0] d, logic [7:0] k, bit l, bit r,
                                bit eov, logic [63:0] eod, logic [7:0] eok, bit eol,
                                logic [3:0] etr, logic [1:0] eg, bit eb, int ec);
        vec_t v;
        v.port = port; v.vld = vld; v.data = d; v.keep = k; v.last = l; v.rdy = r;
        v.e_ov = eov; v.e_od = eod; v.e_ok = eok; v.e_ol = eol;
        v.e_tr = etr; v.e_gid = eg; v.e_busy = eb; v.e_cnt = ec;
        return v;
    endfunction

    vec_t tbl[13];

    // ---------------- source driver + reference model ----------------
    int  q_len[N][$];
    int  cur_beat[N];
    int  pkt_no[N];
    int  delay[N];
    int  drop_beat[N];
    int  drop_len[N];
    bit  acc[N];
    bit  rand_gaps;
    bit  rand_rdy;
    int  order[$];
    int  beat_t[$];
    int  cyc;

    int  m_owner;
    int  m_gap;
    int  m_last;
    int  m_gid;
    int  m_cnt;

    function automatic logic [63:0] mkdata(int p, int n, int b);
        return {8'(p), 8'hC5, 16'(n), 32'(b * 7919 + 1)};
    endfunction

    function automatic logic [7:0] mkkeep(int p, int n, int b);
        return 8'(8'hFF >> ((p + n + b) % 8));
    endfunction

    task automatic src_clear();
        for (int p = 0; p < N; p++) begin
            q_len[p].delete();
            cur_beat[p] = 0; pkt_no[p] = 0; delay[p] = 0;
            drop_beat[p] = -1; drop_len[p] = 0; acc[p] = 0;
        end
        rand_gaps = 0; rand_rdy = 0;
        order.delete(); beat_t.delete(); cyc = 0;
        m_owner = -1; m_gap = 0; m_last = N - 1; m_gid = 0; m_cnt = 0;
    endtask

    task automatic drive_sources();
        for (int p = 0; p < N; p++) begin
            if (q_len[p].size() > 0 && delay[p] == 0) begin
                in_tvalid[p]         = 1'b1;
                in_tdata[64*p +: 64] = mkdata(p, pkt_no[p], cur_beat[p]);
                in_tkeep[8*p +: 8]   = mkkeep(p, pkt_no[p], cur_beat[p]);
                in_tlast[p]          = (cur_beat[p] == q_len[p][0] - 1);
            end else begin
                in_tvalid[p]         = 1'b0;
                in_tdata[64*p +: 64] = {8'(p), 56'hBAD};
                in_tkeep[8*p +: 8]   = 8'h5A;
                in_tlast[p]          = 1'b1;
            end
        end
        out_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    task automatic advance_sources();
        for (int p = 0; p < N; p++) begin
            bit was_valid;
            was_valid = in_tvalid[p];
            if (acc[p]) begin
                cur_beat[p]++;
                if (cur_beat[p] == q_len[p][0]) begin
                    void'(q_len[p].pop_front());
                    cur_beat[p] = 0;
                    pkt_no[p]++;
                end
                if (drop_beat[p] == cur_beat[p]) begin
                    delay[p]     = drop_len[p];
                    drop_beat[p] = -1;
                end
            end else if (delay[p] > 0) begin
                delay[p]--;
            end
            if (rand_gaps && delay[p] == 0 && (acc[p] || !was_valid) && $urandom_range(0, 3) == 0)
                delay[p] = $urandom_range(1, 3);
        end
    endtask

    // Called at the negedge: compare this cycle's outputs, then step the model.
    task automatic model_check();
        logic [112:0] exp_v, act_v;
        logic [3:0]   e_tr;
        logic [63:0]  e_od;
        logic [7:0]   e_ok;
        bit           e_ov, e_ol;
        e_tr = 4'd0; e_od = 64'd0; e_ok = 8'd0; e_ov = 0; e_ol = 0;
        if (m_owner >= 0) begin
            e_od = in_tdata[64*m_owner +: 64];
            e_ok = in_tkeep[8*m_owner +: 8];
            e_ov = in_tvalid[m_owner];
            e_ol = in_tlast[m_owner];
            if (out_tready) e_tr[m_owner] = 1'b1;
        end
        exp_v = {e_ov, e_ol, e_od, e_ok, e_tr, 2'(m_gid), (m_owner >= 0), 32'(m_cnt)};
        act_v = {s_ov, s_ol, s_od, s_ok, s_tr, s_gid, s_busy, s_cnt};
        chk($sformatf("cycle%0d", cyc), 128'(act_v), 128'(exp_v));
        if (s_ov && out_tready) beat_t.push_back(cyc);
        for (int p = 0; p < N; p++) acc[p] = in_tvalid[p] && e_tr[p];

        if (m_owner >= 0) begin
            if (e_ov && out_tready && e_ol) begin
                $display("pkt %0d: port %0d done, pkt_count %0d", m_cnt, m_owner, m_cnt + 1);
                order.push_back(m_owner);
                m_cnt++;
                m_owner = -1;
                m_gap   = sel_g ? 3 : 0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int p;
                p = (m_last + k) % N;
                if (m_owner < 0 && in_tvalid[p]) begin
                    m_owner = p; m_last = p; m_gid = p;
                end
            end
        end
        cyc++;
    endtask

    task automatic run_model(input string name, input int max_cycles);
        bit done;
        done = 0;
        for (int c = 0; c < max_cycles; c++) begin
            bit empty;
            empty = 1;
            for (int p = 0; p < N; p++) if (q_len[p].size() > 0) empty = 0;
            if (empty && m_owner < 0 && m_gap == 0) begin
                done = 1;
                break;
            end
            drive_sources();
            @(negedge clk);
            model_check();
            @(posedge clk); #1;
            advance_sources();
        end
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: not drained, expected drain within %0d cycles", name, max_cycles);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_tvalid = '1; in_tlast = '1; in_tdata = '1; in_tkeep = '1;
        out_tready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("reset_nogap", {ov0, ol0, busy0, tr0, gid0, cnt0}, 128'd0);
        chk("reset_gap",   {ov3, ol3, busy3, tr3, gid3, cnt3}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_tvalid = '0; in_tlast = '0; in_tdata = '0; in_tkeep = '0;
    endtask

    initial begin
        // port, vld, data, keep, last, rdy | ov, od, ok, ol, tready, gid, busy, cnt
        tbl[0]  = mv(2, 1, 64'h11, 8'hFF, 0, 1,  0, 64'h0,  8'h00, 0, 4'b0000, 2'd0, 0, 0);
        tbl[1]  = mv(2, 1, 64'h11, 8'hFF, 0, 1,  1, 64'h11, 8'hFF, 0, 4'b0100, 2'd2, 1, 0);
        tbl[2]  = mv(2, 1, 64'h22, 8'hFF, 0, 1,  1, 64'h22, 8'hFF, 0, 4'b0100, 2'd2, 1, 0);
        tbl[3]  = mv(2, 1, 64'h33, 8'h0F, 1, 1,  1, 64'h33, 8'h0F, 1, 4'b0100, 2'd2, 1, 0);
        tbl[4]  = mv(2, 0, 64'h0,  8'h00, 0, 1,  0, 64'h0,  8'h00, 0, 4'b0000, 2'd2, 0, 1);
        tbl[5]  = mv(1, 1, 64'hA1, 8'hFF, 0, 1,  0, 64'h0,  8'h00, 0, 4'b0000, 2'd2, 0, 1);
        tbl[6]  = mv(1, 1, 64'hA1, 8'hFF, 0, 1,  1, 64'hA1, 8'hFF, 0, 4'b0010, 2'd1, 1, 1);
        tbl[7]  = mv(1, 1, 64'hA2, 8'hFF, 0, 0,  1, 64'hA2, 8'hFF, 0, 4'b0000, 2'd1, 1, 1);
        tbl[8]  = mv(1, 1, 64'hA2, 8'hFF, 0, 0,  1, 64'hA2, 8'hFF, 0, 4'b0000, 2'd1, 1, 1);
        tbl[9]  = mv(1, 1, 64'hA2, 8'hFF, 0, 1,  1, 64'hA2, 8'hFF, 0, 4'b0010, 2'd1, 1, 1);
        tbl[10] = mv(1, 1, 64'hA3, 8'hFF, 0, 1,  1, 64'hA3, 8'hFF, 0, 4'b0010, 2'd1, 1, 1);
        tbl[11] = mv(1, 1, 64'hA4, 8'h3F, 1, 1,  1, 64'hA4, 8'h3F, 1, 4'b0010, 2'd1, 1, 1);
        tbl[12] = mv(1, 0, 64'h0,  8'h00, 0, 1,  0, 64'h0,  8'h00, 0, 4'b0000, 2'd1, 0, 2);

        sel_g = 0;
        src_clear();

        // Directed table: single-beat-stream source, then a stalled packet.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            for (int p = 0; p < N; p++) begin
                in_tdata[64*p +: 64] = {8'(p), 56'hBAD};
                in_tkeep[8*p +: 8]   = 8'h5A;
            end
            in_tvalid = '0;
            in_tlast  = '1;
            in_tvalid[tbl[i].port]            = tbl[i].vld;
            in_tdata[64*tbl[i].port +: 64]    = tbl[i].data;
            in_tkeep[8*tbl[i].port +: 8]      = tbl[i].keep;
            in_tlast[tbl[i].port]             = tbl[i].last;
            out_tready                        = tbl[i].rdy;
            @(negedge clk);
            $display("vec %0d: port %0d vld %0d data %0h -> out_tvalid %0d out_tdata %0h", i,
                     tbl[i].port, tbl[i].vld, tbl[i].data, ov0, od0);
            chk($sformatf("table%0d", i),
                {ov0, ol0, od0, ok0, tr0, gid0, busy0, cnt0},
                {tbl[i].e_ov, tbl[i].e_ol, tbl[i].e_od, tbl[i].e_ok, tbl[i].e_tr,
                 tbl[i].e_gid, tbl[i].e_busy, 32'(tbl[i].e_cnt)});
            @(posedge clk); #1;
        end

        // All ports hold 2-beat packets from reset; port 0 has a second one.
        do_reset();
        sel_g = 0; src_clear();
        for (int p = 0; p < N; p++) q_len[p].push_back(2);
        q_len[0].push_back(2);
        run_model("all_ports", 200);
        chk("rr_npkts", 128'(order.size()), 128'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            chk($sformatf("rr_order%0d", i), 128'(order[i]), 128'(i % N));
        chk("rr_count", 128'(cnt0), 128'd5);

        // GAP_CYCLES=3: two single-beat packets are separated by 4 idle cycles.
        do_reset();
        sel_g = 1; src_clear();
        q_len[0].push_back(1);
        q_len[1].push_back(1);
        run_model("gap", 100);
        chk("gap_beats", 128'(beat_t.size()), 128'd2);
        if (beat_t.size() == 2)
            chk("gap_idle_cycles", 128'(beat_t[1] - beat_t[0] - 1), 128'd4);

        // Port 3 stalls 5 cycles mid-packet while port 0 waits.
        do_reset();
        sel_g = 0; src_clear();
        q_len[3].push_back(3);
        q_len[0].push_back(1);
        delay[0] = 3;
        drop_beat[3] = 1; drop_len[3] = 5;
        run_model("drop", 200);
        chk("drop_npkts", 128'(order.size()), 128'd2);
        if (order.size() == 2) begin
            chk("drop_first", 128'(order[0]), 128'd3);
            chk("drop_second", 128'(order[1]), 128'd0);
        end

        // Reset during beat 2 of a 4-beat packet from port 1.
        do_reset();
        sel_g = 0; src_clear();
        q_len[0].push_back(1);
        run_model("pre_rst", 50);
        in_tvalid = 4'b0010; in_tlast = '0; out_tready = 1'b1;
        in_tdata[64*1 +: 64] = 64'hB1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_beat1", {ov0, od0, gid0}, {1'b1, 64'hB1, 2'd1});
        @(posedge clk); #1;
        in_tdata[64*1 +: 64] = 64'hB2;
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_after", {ov0, ol0, busy0, tr0, cnt0}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_tvalid = '1; in_tlast = '1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("postrst_grant", {gid0, busy0, ov0, tr0}, {2'd0, 1'b1, 1'b1, 4'b0001});
        @(posedge clk); #1;

        // Randomized traffic with source bubbles and downstream back-pressure.
        for (int g = 0; g < 2; g++) begin
            do_reset();
            sel_g = (g == 1); src_clear();
            rand_gaps = 1; rand_rdy = 1;
            for (int p = 0; p < N; p++)
                for (int k = 0; k < 6; k++) q_len[p].push_back($urandom_range(1, 5));
            run_model(g ? "random_gap" : "random", 4000);
            chk(g ? "random_gap_count" : "random_count", 128'(s_cnt), 128'(6 * N));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
